adc_scan_sequencer: RTL and testbench

//  Multi-channel ADC conversion scheduler sitting between the myip_adc_new AXI4-Lite

---
 rtl/adc_scan_sequencer.sv | 151 +++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// rtl/adc_scan_sequencer.sv - scans enabled ADC channels through one shared conversion core
// Periodic or software-triggered scans, per-channel result hold with sticky valid and timeout flags.
module adc_scan_sequencer #(
  parameter int NUM_CH   = 4,
  parameter int CH_W     = 2,
  parameter int DATA_W   = 12,
  parameter int PERIOD_W = 24,
  parameter int TIMEOUT  = 1023
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cfg_enable,
  input  logic [NUM_CH-1:0]        cfg_ch_mask,
  input  logic [PERIOD_W-1:0]      cfg_period,
  input  logic                     sw_trigger,
  output logic                     conv_start,
  output logic [CH_W-1:0]          conv_ch,
  input  logic                     conv_done,
  input  logic [DATA_W-1:0]        conv_data,
  output logic [NUM_CH*DATA_W-1:0] result_data,
  output logic [NUM_CH-1:0]        result_valid,
  input  logic [NUM_CH-1:0]        result_clr,
  output logic                     scan_done,
  output logic                     busy,
  output logic                     timeout_err,
  input  logic                     err_clr
);

  localparam int TO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_NEXT} state_t;

  state_t              r_state;
  logic [PERIOD_W-1:0] r_timer;
  logic                r_pending;
  logic [NUM_CH-1:0]   r_scan_mask;
  logic [CH_W-1:0]     r_ch_idx;
  logic [TO_W-1:0]     r_to_cnt;
  logic [DATA_W-1:0]   r_result [NUM_CH];
  logic [NUM_CH-1:0]   r_valid;
  logic                r_conv_start;
  logic                r_scan_done;
  logic                r_busy;
  logic                r_timeout_err;

  logic [PERIOD_W-1:0] w_limit;
  logic                w_period_hit;
  logic                w_req;
  logic [CH_W-1:0]     w_first_ch;
  logic [CH_W-1:0]     w_next_ch;
  logic                w_has_next;
  logic                w_wait_exit;

  // Descending loops leave the lowest qualifying channel as the final assignment.
  always_comb begin
    w_limit      = (cfg_period == '0) ? '0 : cfg_period - PERIOD_W'(1);
    w_period_hit = cfg_enable && (r_timer >= w_limit);
    w_req        = w_period_hit || sw_trigger;
    w_first_ch   = '0;
    w_next_ch    = '0;
    w_has_next   = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (cfg_ch_mask[i]) w_first_ch = CH_W'(i);
      if (r_scan_mask[i] && (i > int'(r_ch_idx))) begin
        w_next_ch  = CH_W'(i);
        w_has_next = 1'b1;
      end
    end
    w_wait_exit = conv_done || (r_to_cnt == TO_W'(TIMEOUT));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_pending     <= 1'b0;
      r_scan_mask   <= '0;
      r_ch_idx      <= '0;
      r_to_cnt      <= '0;
      r_valid       <= '0;
      r_conv_start  <= 1'b0;
      r_scan_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) r_result[i] <= '0;
    end else begin
      r_conv_start <= 1'b0;
      r_scan_done  <= 1'b0;
      // Clears are applied first so a same-cycle store or timeout below wins.
      r_valid <= r_valid & ~result_clr;
      if (err_clr) r_timeout_err <= 1'b0;
      if (!cfg_enable || w_period_hit) r_timer <= '0;
      else r_timer <= r_timer + PERIOD_W'(1);
      if (w_req && (r_state != S_IDLE)) r_pending <= 1'b1;

      case (r_state)
        S_IDLE: begin
          r_pending <= 1'b0;
          if ((w_req || r_pending) && (cfg_ch_mask != '0)) begin
            r_scan_mask  <= cfg_ch_mask;
            r_ch_idx     <= w_first_ch;
            r_conv_start <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_START;
          end
        end
        S_START: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          if (conv_done) begin
            r_result[r_ch_idx] <= conv_data;
            r_valid[r_ch_idx]  <= 1'b1;
          end else if (w_wait_exit) begin
            r_timeout_err <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
          if (w_wait_exit) begin
            r_scan_done <= !w_has_next;
            r_state     <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (w_has_next) begin
            r_ch_idx     <= w_next_ch;
            r_conv_start <= 1'b1;
            r_state      <= S_START;
          end else begin
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign conv_start   = r_conv_start;
  assign conv_ch      = r_ch_idx;
  assign scan_done    = r_scan_done;
  assign busy         = r_busy;
  assign timeout_err  = r_timeout_err;
  assign result_valid = r_valid;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
    assign result_data[g*DATA_W +: DATA_W] = r_result[g];
  end

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// tb/tb_adc_scan_sequencer.sv - scoreboard bench for adc_scan_sequencer
// ADC core model answers conv_start; per-scan expectations are queued at trigger time.
module tb_adc_scan_sequencer;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [3:0]  cfg_ch_mask = '0;
  logic [23:0] cfg_period = '0;
  logic        sw_trigger = 1'b0;
  logic        conv_start;
  logic [1:0]  conv_ch;
  logic        conv_done = 1'b0;
  logic [11:0] conv_data = '0;
  logic [47:0] result_data;
  logic [3:0]  result_valid;
  logic [3:0]  result_clr = '0;
  logic        scan_done;
  logic        busy;
  logic        timeout_err;
  logic        err_clr = 1'b0;

  adc_scan_sequencer #(.NUM_CH(4), .CH_W(2), .DATA_W(12), .PERIOD_W(24), .TIMEOUT(TO)) dut (
    .clock(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_ch_mask(cfg_ch_mask),
    .cfg_period(cfg_period), .sw_trigger(sw_trigger), .conv_start(conv_start), .conv_ch(conv_ch),
    .conv_done(conv_done), .conv_data(conv_data), .result_data(result_data),
    .result_valid(result_valid), .result_clr(result_clr), .scan_done(scan_done), .busy(busy),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [47:0] d;
    logic [3:0]  v;
    logic        e;
  } snap_t;

  int          n_checks = 0;
  int          n_err = 0;
  logic [1:0]  exp_ch_q[$];
  snap_t       snap_q[$];

  // Bench-side model state, written by the stimulus process only
  logic [11:0] ch_data [4];
  logic [3:0]  no_done = '0;
  int          lat = 3;
  logic        clr_on_done = 1'b0;
  logic [3:0]  manual_clr = '0;
  int          late_done_cyc = -1;
  logic        periodic = 1'b0;
  logic [11:0] mdl_res [4];
  logic [3:0]  mdl_valid = '0;
  logic        mdl_err = 1'b0;

  // Monitor state, written by the ADC model process only
  int          cyc = 0;
  int          cd = 0;
  logic [1:0]  cur_ch = '0;
  int          n_starts = 0;
  int          n_sd = 0;
  int          n_busy = 0;
  int          last_start_cyc = 0;
  int          last_sd_cyc = 0;
  int          per_prev = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pack_mdl();
    logic [47:0] d;
    for (int c = 0; c < 4; c++) d[c*12 +: 12] = mdl_res[c];
    return d;
  endfunction

  task automatic queue_scan(input logic [3:0] mask, input bit with_snap);
    snap_t s;
    for (int c = 0; c < 4; c++) begin
      if (mask[c]) begin
        exp_ch_q.push_back(2'(c));
        if (no_done[c]) mdl_err = 1'b1;
        else begin
          mdl_res[c]   = ch_data[c];
          mdl_valid[c] = 1'b1;
        end
      end
    end
    s.d = pack_mdl();
    s.v = mdl_valid;
    s.e = mdl_err;
    if (with_snap) snap_q.push_back(s);
  endtask

  task automatic trigger();
    @(posedge clk); #1 sw_trigger = 1'b1;
    @(posedge clk); #1 sw_trigger = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sd(input int target, input int budget);
    int k = 0;
    while (n_sd < target && k < budget) begin
      @(posedge clk);
      k++;
    end
    if (n_sd < target) chk("wait_scan_done", 64'(n_sd), 64'(target));
    cycles(3);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, conv_start, 0);
    chk({tag, "_ch"}, conv_ch, 0);
    chk({tag, "_data"}, result_data, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_sd"}, scan_done, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, timeout_err, 0);
  endtask

  // ADC core model and output monitor, all activity on the falling edge
  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      cyc++;
      conv_done  = 1'b0;
      result_clr = manual_clr;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          conv_done = 1'b1;
          conv_data = ch_data[cur_ch];
          if (clr_on_done && cur_ch == 2'd0) result_clr = result_clr | 4'b0001;
        end
      end
      if (late_done_cyc == cyc) begin
        conv_done = 1'b1;
        conv_data = 12'hABC;
      end
      if (!periodic) per_prev = 0;
      if (busy === 1'b1) n_busy++;
      if (conv_start === 1'b1) begin
        n_starts++;
        if (cd != 0) chk("start_overlap", 1, 0);
        if (exp_ch_q.size() == 0) chk("start_unexpected", 1, 0);
        else chk("conv_ch", conv_ch, exp_ch_q.pop_front());
        if (periodic && per_prev != 0) chk("period", 64'(cyc - per_prev), 100);
        if (periodic) per_prev = cyc;
        last_start_cyc = cyc;
        cur_ch = conv_ch;
        cd = no_done[conv_ch] ? 0 : lat;
      end
      if (scan_done === 1'b1) begin
        n_sd++;
        last_sd_cyc = cyc;
        if (snap_q.size() == 0) chk("scan_done_unexpected", 1, 0);
        else begin
          s = snap_q.pop_front();
          chk("sd_result_data", result_data, s.d);
          chk("sd_result_valid", result_valid, s.v);
          chk("sd_timeout_err", timeout_err, s.e);
        end
      end
    end
  end

  initial begin
    int base_st;
    int base_sd;
    int base_busy;
    for (int c = 0; c < 4; c++) begin
      ch_data[c] = '0;
      mdl_res[c] = '0;
    end
    cycles(3);
    chk_all_zero("reset");
    #1 reset = 1'b0;

    // 1: two-channel software scan
    ch_data[0] = 12'h123;
    ch_data[2] = 12'h456;
    cfg_ch_mask = 4'b0101;
    queue_scan(4'b0101, 1);
    trigger();
    wait_sd(1, 100);
    chk("t1_busy_idle", busy, 0);

    // 2: periodic scanning, then disable
    lat = 2;
    ch_data[0] = 12'h321;
    cfg_ch_mask = 4'b0001;
    cfg_period = 24'd100;
    for (int k = 0; k < 3; k++) queue_scan(4'b0001, 1);
    base_st = n_starts;
    periodic = 1'b1;
    cfg_enable = 1'b1;
    for (int k = 0; k < 450 && n_starts < base_st + 3; k++) cycles(1);
    chk("t2_three_starts", 64'(n_starts - base_st), 3);
    cycles(10);
    cfg_enable = 1'b0;
    periodic = 1'b0;
    cycles(300);
    chk("t2_no_start_after_disable", 64'(n_starts - base_st), 3);
    chk("t2_scans", 64'(n_sd), 4);

    // 3: store ch1, then let ch1 time out in a two-channel scan
    lat = 3;
    ch_data[1] = 12'h777;
    cfg_ch_mask = 4'b0010;
    queue_scan(4'b0010, 1);
    trigger();
    wait_sd(5, 100);
    ch_data[0] = 12'h0AA;
    ch_data[1] = 12'hBBB;
    no_done = 4'b0010;
    cfg_ch_mask = 4'b0011;
    queue_scan(4'b0011, 1);
    trigger();
    wait_sd(6, 100);
    chk("t3_timeout_len", 64'(last_sd_cyc - last_start_cyc), TO + 2);
    no_done = '0;
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    mdl_err = 1'b0;
    chk("t3_err_cleared", timeout_err, 0);

    // 4: empty mask consumes the trigger
    base_st = n_starts;
    base_sd = n_sd;
    base_busy = n_busy;
    cfg_ch_mask = 4'b0000;
    trigger();
    cycles(10);
    chk("t4_no_start", 64'(n_starts), 64'(base_st));
    chk("t4_no_busy", 64'(n_busy), 64'(base_busy));
    chk("t4_no_scan_done", 64'(n_sd), 64'(base_sd));

    // 5: store beats clear; extra triggers fold into one follow-up scan
    ch_data[0] = 12'h5A5;
    ch_data[2] = 12'h3C3;
    cfg_ch_mask = 4'b0101;
    clr_on_done = 1'b1;
    queue_scan(4'b0101, 1);
    queue_scan(4'b0101, 1);
    base_sd = n_sd;
    trigger();
    cycles(3);
    trigger();
    cycles(2);
    trigger();
    wait_sd(base_sd + 2, 100);
    cycles(30);
    chk("t5_one_followup", 64'(n_sd - base_sd), 2);
    clr_on_done = 1'b0;
    @(posedge clk); #1 manual_clr = 4'b0001;
    @(posedge clk); #1 manual_clr = 4'b0000;
    cycles(2);
    mdl_valid[0] = 1'b0;
    chk("t5_clear_alone", result_valid, mdl_valid);

    // 6: reset during WAIT aborts; late done ignored; fresh scan works
    no_done = 4'b0001;
    cfg_ch_mask = 4'b0001;
    queue_scan(4'b0001, 0);
    base_st = n_starts;
    trigger();
    for (int k = 0; k < 20 && n_starts == base_st; k++) cycles(1);
    cycles(3);
    base_sd = n_sd;
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk); #1;
    chk_all_zero("t6_reset");
    reset = 1'b0;
    late_done_cyc = cyc + 2;
    cycles(20);
    chk("t6_no_scan_done", 64'(n_sd), 64'(base_sd));
    chk("t6_late_done_valid", result_valid, 0);
    chk("t6_late_done_data", result_data, 0);
    no_done = '0;
    for (int c = 0; c < 4; c++) mdl_res[c] = '0;
    mdl_valid = '0;
    mdl_err = 1'b0;
    ch_data[0] = 12'h9E1;
    queue_scan(4'b0001, 1);
    trigger();
    wait_sd(base_sd + 1, 100);

    chk("end_exp_ch_empty", 64'(exp_ch_q.size()), 0);
    chk("end_snap_empty", 64'(snap_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
